// File: rtl/conv_1x1_accum_align_pkg.sv
// Shared types and elaboration helpers for the 1x1 convolution accumulate/align back end.
package conv_1x1_accum_align_pkg;

    localparam logic [0:0] ST_PREFILL = 1'b0;
    localparam logic [0:0] ST_STREAM  = 1'b1;

    // Counter width that stays legal when the count collapses to a single value.
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic longint round_bias(input int shift);
        return (shift > 0) ? (longint'(1) <<< (shift - 1)) : longint'(0);
    endfunction

    function automatic longint sat_max(input int width);
        return (longint'(1) <<< (width - 1)) - longint'(1);
    endfunction

endpackage

// File: rtl/conv_1x1_accum_align_fifo.sv
// Synchronous FIFO with inferred RAM, extra pointer MSB for full/empty, synchronous clear.
// Latency: a written word is readable the cycle after the write; read data is combinational.
// Backpressure: none; writes to a full FIFO are ignored unless a read happens in the same cycle.
module conv_1x1_accum_align_fifo #(
    parameter int DW    = 16,
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          wr_en,
    input  logic [DW-1:0] wr_dat,
    input  logic          rd_en,
    output logic [DW-1:0] rd_dat,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   level
);

    localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

    logic [DW-1:0] mem [DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic          do_wr;
    logic          do_rd;

    assign empty  = (wr_ptr == rd_ptr);
    assign full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign level  = wr_ptr - rd_ptr;
    assign do_rd  = rd_en && !empty;
    assign do_wr  = wr_en && (!full || do_rd);
    assign rd_dat = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_rd) rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_dat;
    end

endmodule

// File: rtl/conv_1x1_accum_align.sv
// Accumulates CHANNEL_NUM_IN partial products per pixel, rounds/shifts/saturates, buffers until PREFILL.
// Latency: FIFO write 1 clk after the last channel; first output 3 clk after the last channel at PREFILL=1.
// Backpressure: none upstream; results arriving at a full FIFO with no read are dropped and flagged.
module conv_1x1_accum_align
    import conv_1x1_accum_align_pkg::*;
#(
    parameter int DATA_WIDTH     = 16,
    parameter int ACC_WIDTH      = 32,
    parameter int CHANNEL_NUM_IN = 128,
    parameter int SHIFT          = 8,
    parameter int SATURATE       = 1,
    parameter int FIFO_DEPTH     = 64,
    parameter int PREFILL        = 64
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          valid_in,
    input  logic [DATA_WIDTH-1:0]         pxl_in,
    input  logic                          flush,
    output logic [DATA_WIDTH-1:0]         pxl_out,
    output logic                          valid_out,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow
);

    localparam int CW = clog2_min1(CHANNEL_NUM_IN);
    localparam int LW = $clog2(FIFO_DEPTH) + 1;
    localparam int XW = ACC_WIDTH + 1;
    localparam logic [CW-1:0]        CH_LAST     = CW'(CHANNEL_NUM_IN - 1);
    localparam logic [LW-1:0]        PREFILL_LVL = LW'(PREFILL);
    localparam logic signed [XW-1:0] RND         = XW'(round_bias(SHIFT));
    localparam logic signed [XW-1:0] SAT_MAX     = XW'(sat_max(DATA_WIDTH));
    localparam logic signed [XW-1:0] SAT_MIN     = -SAT_MAX - XW'(1);

    logic [CW-1:0]                ch_cnt;
    logic signed [DATA_WIDTH-1:0] pxl_s;
    logic signed [ACC_WIDTH-1:0]  pxl_ext;
    logic signed [ACC_WIDTH-1:0]  acc;
    logic signed [ACC_WIDTH-1:0]  acc_next;
    logic signed [ACC_WIDTH-1:0]  sum_q;
    logic                         sum_vld;
    logic                         last_ch;

    assign pxl_s    = pxl_in;
    assign pxl_ext  = ACC_WIDTH'(pxl_s);
    assign last_ch  = (ch_cnt == CH_LAST);
    // Channel 0 starts a fresh pixel, so the stale accumulator is never added in.
    assign acc_next = ((ch_cnt == '0) ? '0 : acc) + pxl_ext;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ch_cnt  <= '0;
            acc     <= '0;
            sum_q   <= '0;
            sum_vld <= 1'b0;
        end else if (flush) begin
            ch_cnt  <= '0;
            acc     <= '0;
            sum_q   <= '0;
            sum_vld <= 1'b0;
        end else begin
            sum_vld <= valid_in && last_ch;
            if (valid_in) begin
                acc <= acc_next;
                if (last_ch) begin
                    ch_cnt <= '0;
                    sum_q  <= acc_next;
                end else begin
                    ch_cnt <= ch_cnt + CW'(1);
                end
            end
        end
    end

    // One guard bit keeps the rounding bias from wrapping a near-max sum.
    logic signed [XW-1:0]         sum_x;
    logic signed [XW-1:0]         rnd_sum;
    logic signed [XW-1:0]         shifted;
    logic [DATA_WIDTH-1:0]        res;

    assign sum_x   = XW'(sum_q);
    assign rnd_sum = sum_x + RND;
    assign shifted = rnd_sum >>> SHIFT;

    always_comb begin
        res = shifted[DATA_WIDTH-1:0];
        if (SATURATE != 0) begin
            if (shifted > SAT_MAX)      res = SAT_MAX[DATA_WIDTH-1:0];
            else if (shifted < SAT_MIN) res = SAT_MIN[DATA_WIDTH-1:0];
        end
    end

    logic [0:0]            state;
    logic                  rd_go;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [DATA_WIDTH-1:0] rd_dat;

    assign rd_go = (state == ST_STREAM) && !fifo_empty;

    conv_1x1_accum_align_fifo #(
        .DW    (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .reset  (reset),
        .clear  (flush),
        .wr_en  (sum_vld),
        .wr_dat (res),
        .rd_en  (rd_go),
        .rd_dat (rd_dat),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .level  (fifo_level)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_PREFILL;
            pxl_out   <= '0;
            valid_out <= 1'b0;
            overflow  <= 1'b0;
        end else if (flush) begin
            state     <= ST_PREFILL;
            pxl_out   <= '0;
            valid_out <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            if ((state == ST_PREFILL) && (fifo_level >= PREFILL_LVL)) state <= ST_STREAM;
            valid_out <= rd_go;
            if (rd_go) pxl_out <= rd_dat;
            if (sum_vld && fifo_full && !rd_go) overflow <= 1'b1;
        end
    end

endmodule
